// File: rtl/multdiv_ctrl.sv
// Sequencer between DX and the multi-cycle multdiv unit: registers operands,
// emits a one-cycle start pulse, stalls the front end, and returns one writeback token.
module multdiv_ctrl #(
  parameter int          LATENCY_MAX = 40,
  parameter logic [31:0] STATUS_MUL  = 32'd4,
  parameter logic [31:0] STATUS_DIV  = 32'd5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dx_valid,
  input  logic [31:0] dx_ir,
  input  logic [31:0] dx_a,
  input  logic [31:0] dx_b,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_reg,
  output logic        busy,
  output logic        timeout
);
  localparam int CW = $clog2(LATENCY_MAX + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          op_div;
  logic [4:0]    rd_q;
  logic          is_md;
  logic          cnt_last;
  logic          unused_dx_ir;

  assign is_md = dx_valid && (dx_ir[31:27] == 5'b00000) &&
                 ((dx_ir[6:2] == 5'b00110) || (dx_ir[6:2] == 5'b00111));
  assign unused_dx_ir = ^{dx_ir[21:7], dx_ir[1:0]};

  // This WAIT cycle is the last one allowed before declaring a timeout.
  assign cnt_last = (cnt == CW'(LATENCY_MAX - 1));

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (is_md) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (md_resultRDY || cnt_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Reset masks the combinational outputs so a reset cycle never issues or stalls.
  always_comb begin
    stall        = 1'b0;
    md_ctrl_mult = 1'b0;
    md_ctrl_div  = 1'b0;
    wb_valid     = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE:  stall = is_md && !reset;
      START: begin
        stall        = !reset;
        md_ctrl_mult = !op_div && !reset;
        md_ctrl_div  = op_div && !reset;
      end
      WAIT:  stall = !reset;
      DONE:  wb_valid = !reset;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      md_operandA <= '0;
      md_operandB <= '0;
      op_div      <= 1'b0;
      rd_q        <= '0;
      cnt         <= '0;
      wb_data     <= '0;
      wb_reg      <= '0;
      timeout     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (is_md) begin
          md_operandA <= dx_a;
          md_operandB <= dx_b;
          op_div      <= dx_ir[2];
          rd_q        <= dx_ir[26:22];
        end
        START: cnt <= '0;
        WAIT: begin
          if (cnt != CW'(LATENCY_MAX)) cnt <= cnt + CW'(1);
          // Ready takes priority over the timeout limit in the same cycle.
          if (md_resultRDY) begin
            wb_data <= md_exception ? (op_div ? STATUS_DIV : STATUS_MUL) : md_result;
            wb_reg  <= md_exception ? 5'd30 : rd_q;
          end else if (cnt_last) begin
            timeout <= 1'b1;
            wb_data <= '0;
            wb_reg  <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl: decode, pulse, stall window, tokens,
// exceptions, timeout, ready-at-limit and mid-operation reset.
module tb_multdiv_ctrl;
  logic        clock = 1'b0;
  logic        reset;
  logic        dx_valid;
  logic [31:0] dx_ir, dx_a, dx_b;
  logic [31:0] md_operandA, md_operandB;
  logic        md_ctrl_mult, md_ctrl_div;
  logic [31:0] md_result;
  logic        md_exception, md_resultRDY;
  logic        stall, wb_valid, busy, timeout;
  logic [31:0] wb_data;
  logic [4:0]  wb_reg;

  int n_cmp = 0;
  int n_err = 0;
  int mult_cnt = 0, div_cnt = 0, wb_cnt = 0;

  multdiv_ctrl #(.LATENCY_MAX(40), .STATUS_MUL(32'd4), .STATUS_DIV(32'd5)) dut (
    .clock(clock), .reset(reset), .dx_valid(dx_valid), .dx_ir(dx_ir),
    .dx_a(dx_a), .dx_b(dx_b), .md_operandA(md_operandA), .md_operandB(md_operandB),
    .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div), .md_result(md_result),
    .md_exception(md_exception), .md_resultRDY(md_resultRDY), .stall(stall),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_reg(wb_reg), .busy(busy),
    .timeout(timeout)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (md_ctrl_mult) mult_cnt++;
    if (md_ctrl_div)  div_cnt++;
    if (wb_valid)     wb_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, exp finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] mk_r(input logic [4:0] rd, input logic [4:0] aluop);
    return {5'b00000, rd, 5'd1, 5'd2, 5'd0, aluop, 2'b00};
  endfunction

  task automatic idle_chk(input string tag);
    dx_valid = 1'b0;
    #2;
    chk({tag, " idle busy"},  {31'd0, busy},     32'd0);
    chk({tag, " idle stall"}, {31'd0, stall},    32'd0);
    chk({tag, " idle wbv"},   {31'd0, wb_valid}, 32'd0);
    tick();
  endtask

  // Drives one md instruction through the whole sequence; ready (if any) at WAIT cycle n_wait.
  task automatic run_md(input string tag, input logic [31:0] ir, input logic [31:0] a,
                        input logic [31:0] b, input bit is_div, input int n_wait,
                        input bit rdy, input bit exc, input logic [31:0] res,
                        input logic [31:0] exp_data, input logic [4:0] exp_reg,
                        input bit exp_to);
    int m0, d0, w0;
    bit st_ok, pl_ok, op_ok;
    m0 = mult_cnt; d0 = div_cnt; w0 = wb_cnt;
    dx_valid = 1'b1; dx_ir = ir; dx_a = a; dx_b = b;
    #2;
    chk({tag, " t stall"}, {31'd0, stall}, 32'd1);
    chk({tag, " t busy"},  {31'd0, busy},  32'd0);
    tick();
    dx_a = ~a; dx_b = ~b;
    #2;
    chk({tag, " start pulse"}, {30'd0, md_ctrl_mult, md_ctrl_div}, {30'd0, !is_div, is_div});
    chk({tag, " start stall"}, {31'd0, stall}, 32'd1);
    chk({tag, " start opA"},   md_operandA, a);
    chk({tag, " start opB"},   md_operandB, b);
    tick();
    st_ok = 1'b1; pl_ok = 1'b1; op_ok = 1'b1;
    for (int k = 1; k <= n_wait; k++) begin
      if (rdy && k == n_wait) begin
        md_resultRDY = 1'b1; md_exception = exc; md_result = res;
      end
      #2;
      if (stall !== 1'b1 || wb_valid !== 1'b0) st_ok = 1'b0;
      if (md_ctrl_mult !== 1'b0 || md_ctrl_div !== 1'b0) pl_ok = 1'b0;
      if (md_operandA !== a || md_operandB !== b) op_ok = 1'b0;
      tick();
      md_resultRDY = 1'b0; md_exception = 1'b0; md_result = 32'hDEAD_BEEF;
    end
    chk({tag, " wait stall"},  {31'd0, st_ok}, 32'd1);
    chk({tag, " wait nopulse"}, {31'd0, pl_ok}, 32'd1);
    #2;
    chk({tag, " done wbv"},     {31'd0, wb_valid}, 32'd1);
    chk({tag, " done data"},    wb_data, exp_data);
    chk({tag, " done reg"},     {27'd0, wb_reg}, {27'd0, exp_reg});
    chk({tag, " done stall"},   {31'd0, stall}, 32'd0);
    chk({tag, " done timeout"}, {31'd0, timeout}, {31'd0, exp_to});
    if (md_operandA !== a || md_operandB !== b) op_ok = 1'b0;
    chk({tag, " ops held"},     {31'd0, op_ok}, 32'd1);
    tick();
    chk({tag, " n mult"}, mult_cnt - m0, is_div ? 0 : 1);
    chk({tag, " n div"},  div_cnt - d0,  is_div ? 1 : 0);
    chk({tag, " n wb"},   wb_cnt - w0,   1);
  endtask

  initial begin
    int m0, w0;
    reset = 1'b1; dx_valid = 1'b0; dx_ir = '0; dx_a = '0; dx_b = '0;
    md_result = '0; md_exception = 1'b0; md_resultRDY = 1'b0;
    tick(); tick();
    chk("rst outs", {md_operandA | md_operandB | wb_data},                32'd0);
    chk("rst bits", {25'd0, md_ctrl_mult, md_ctrl_div, stall, wb_valid, busy, timeout, 1'b0}, 32'd0);
    chk("rst wbreg", {27'd0, wb_reg}, 32'd0);
    reset = 1'b0;
    tick();

    // Non-md instructions never stall.
    dx_valid = 1'b1; dx_ir = mk_r(5'd5, 5'b00000); #2;
    chk("add stall", {31'd0, stall}, 32'd0);
    dx_ir = {5'b00101, 5'd5, 5'd1, 10'd0, 5'b00110, 2'b00}; #2;
    chk("addi stall", {31'd0, stall}, 32'd0);
    dx_valid = 1'b0; dx_ir = mk_r(5'd3, 5'b00110); #2;
    chk("bubble stall", {31'd0, stall}, 32'd0);
    tick();
    chk("nonmd busy", {31'd0, busy}, 32'd0);

    run_md("mul", mk_r(5'd3, 5'b00110), 32'd3, 32'hFFFF_FFF9, 1'b0, 33, 1'b1, 1'b0,
           32'hFFFF_FFEB, 32'hFFFF_FFEB, 5'd3, 1'b0);
    idle_chk("mul");
    run_md("div0", mk_r(5'd4, 5'b00111), 32'd17, 32'd0, 1'b1, 5, 1'b1, 1'b1,
           32'h1234_5678, 32'd5, 5'd30, 1'b0);
    idle_chk("div0");
    run_md("movf", mk_r(5'd6, 5'b00110), 32'h4000_0000, 32'd4, 1'b0, 7, 1'b1, 1'b1,
           32'd0, 32'd4, 5'd30, 1'b0);
    idle_chk("movf");
    run_md("b2b1", mk_r(5'd7, 5'b00110), 32'd10, 32'd11, 1'b0, 3, 1'b1, 1'b0,
           32'd110, 32'd110, 5'd7, 1'b0);
    run_md("b2b2", mk_r(5'd8, 5'b00110), 32'd12, 32'd13, 1'b0, 4, 1'b1, 1'b0,
           32'd156, 32'd156, 5'd8, 1'b0);
    idle_chk("b2b");
    run_md("rd0", mk_r(5'd0, 5'b00111), 32'd20, 32'd4, 1'b1, 2, 1'b1, 1'b0,
           32'd5, 32'd5, 5'd0, 1'b0);
    idle_chk("rd0");
    run_md("rdylim", mk_r(5'd9, 5'b00110), 32'd2, 32'd2, 1'b0, 40, 1'b1, 1'b0,
           32'd4, 32'd4, 5'd9, 1'b0);
    idle_chk("rdylim");
    run_md("tmo", mk_r(5'd10, 5'b00110), 32'd5, 32'd6, 1'b0, 40, 1'b0, 1'b0,
           32'd0, 32'd0, 5'd10, 1'b1);
    idle_chk("tmo");
    chk("tmo sticky1", {31'd0, timeout}, 32'd1);
    run_md("post", mk_r(5'd11, 5'b00111), 32'd9, 32'd3, 1'b1, 6, 1'b1, 1'b0,
           32'd3, 32'd3, 5'd11, 1'b1);
    idle_chk("post");

    // Reset during WAIT cycle 10, then a stale ready.
    m0 = mult_cnt; w0 = wb_cnt;
    dx_valid = 1'b1; dx_ir = mk_r(5'd12, 5'b00110); dx_a = 32'd7; dx_b = 32'd8;
    tick(); tick();
    for (int k = 1; k < 10; k++) tick();
    reset = 1'b1; dx_valid = 1'b0;
    tick();
    reset = 1'b0;
    #2;
    chk("mrst busy",  {31'd0, busy}, 32'd0);
    chk("mrst ops",   md_operandA | md_operandB, 32'd0);
    chk("mrst bits",  {26'd0, md_ctrl_mult, md_ctrl_div, stall, wb_valid, timeout, 1'b0}, 32'd0);
    chk("mrst wb",    {wb_data[26:0], wb_reg}, 32'd0);
    md_resultRDY = 1'b1; md_exception = 1'b1; md_result = 32'h0000_0123;
    tick();
    md_resultRDY = 1'b0; md_exception = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("mrst stale busy", {31'd0, busy}, 32'd0);
    chk("mrst stale data", wb_data, 32'd0);
    chk("mrst n mult", mult_cnt - m0, 1);
    chk("mrst n wb",   wb_cnt - w0,   0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/multdiv_ctrl.md
# multdiv_ctrl

Sequencer between the DX stage of the 5-stage pipeline and the multi-cycle `multdiv` unit. It detects `mul`/`div` in DX, launches the unit with registered operands and a one-cycle start pulse, and stalls the front of the pipeline while the unit runs. When the unit reports ready, it presents one writeback token (data plus destination register) that the pipeline injects into the XM latch in place of the ALU result. It also maps multdiv exceptions to the rstatus convention.

## Interface
- `LATENCY_MAX`, 40: WAIT cycles allowed before declaring a timeout.
- `STATUS_MUL`, 32'd4: rstatus value written on a `mul` exception.
- `STATUS_DIV`, 32'd5: rstatus value written on a `div` exception.

- `clock`  in  1  master clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `dx_valid`  in  1  DX latch holds a real instruction (not a bubble).
- `dx_ir`  in  32  DX instruction word.
- `dx_a`, `dx_b`  in  32  bypassed operands A and B from the DX bypass muxes.
- `md_operandA`, `md_operandB`  out  32  registered operands to `multdiv`.
- `md_ctrl_mult`, `md_ctrl_div`  out  1  one-cycle start pulses to `multdiv`.
- `md_result`  in  32  `multdiv` result.
- `md_exception`  in  1  `multdiv` exception; qualified by `md_resultRDY`.
- `md_resultRDY`  in  1  `multdiv` result-valid.
- `stall`  out  1  hold PC, FD and DX; bubble into XM.
- `wb_valid`  out  1  one-cycle writeback token for XM.
- `wb_data`  out  32  result or rstatus code.
- `wb_reg`  out  5  destination register.
- `busy`  out  1  high in any state except IDLE.
- `timeout`  out  1  sticky error flag; cleared only by reset.

## Operation
- Decode: `is_md` = `dx_valid` & opcode `dx_ir[31:27]`==00000 & ALU op `dx_ir[6:2]` ∈ {00110 mul, 00111 div}. rd = `dx_ir[26:22]`.
- FSM states: IDLE, START, WAIT, DONE.
- **IDLE**
  - `stall` = `is_md`, combinational.
  - On `is_md`: capture `dx_a`→`md_operandA`, `dx_b`→`md_operandB`, op kind, and rd; go to START.
  - `md_resultRDY` is ignored in IDLE.
- **START**
  - Assert exactly one of `md_ctrl_mult`/`md_ctrl_div` for one cycle; `stall`=1.
  - Clear the cycle counter; go to WAIT.
  - `md_resultRDY` is ignored in START.
- **WAIT**
  - `stall`=1. The counter increments each cycle, saturating at `LATENCY_MAX`.
  - On `md_resultRDY`, register the token:
    - `md_exception`=0: `wb_data`=`md_result`, `wb_reg`=rd.
    - `md_exception`=1: `wb_data`=`STATUS_MUL` or `STATUS_DIV` per op kind, `wb_reg`=30.
    - Go to DONE.
  - If the counter reaches `LATENCY_MAX` with no ready: set `timeout`, `wb_data`=0, `wb_reg`=rd; go to DONE.
- **DONE**
  - `wb_valid`=1 and `stall`=0, so DX advances this edge and the pipeline muxes the token into XM.
  - DX decode is ignored in DONE, so the same instruction is never re-issued. Go to IDLE.
- rd=0 without exception: the token is still emitted with `wb_reg`=0; the regfile discards it.
- Operand registers hold their value from START through DONE.
- Width rules: all data is 32-bit, with no extension or truncation. The counter is ceil(log2(`LATENCY_MAX`+1)) bits.

## Timing
- Reset: state=IDLE, counter=0, every output 0 (operands, pulses, `stall`, `wb_*`, `busy`, `timeout`).
- Reset mid-operation (any state): IDLE on the next edge. No start pulse is emitted, and any later stale `md_resultRDY` is ignored.
- Cycle sequence, with the md instruction in DX at cycle t:
  - t: IDLE, `stall`=1.
  - t+1: START, pulse.
  - t+2…: WAIT.
  - Ready sampled at cycle r → DONE at r+1 with `wb_valid`=1.
  - `stall` is high on cycles t through r inclusive.
- Back-to-back md instructions: the second enters DX at r+2 (IDLE) and restarts at START on r+3. There is no overlap.
- `md_resultRDY` and the timeout limit in the same cycle: ready wins and `timeout` is not set.
- `busy` = state≠IDLE, registered.

## Test plan
- `mul r3,r1,r2` with A=3, B=-7, ready 33 cycles after the pulse → one `md_ctrl_mult` pulse; `wb_valid` for 1 cycle with `wb_data`=0xFFFFFFEB, `wb_reg`=3; `stall` high for t…t+34.
- `div r4,r1,r2` with B=0 and `md_exception`=1 at ready → `wb_reg`=30, `wb_data`=5; `md_ctrl_mult` stays 0.
- `mul` with overflow exception → `wb_reg`=30, `wb_data`=4; operand outputs unchanged from START through DONE.
- Two consecutive `mul` in DX → two distinct pulses separated by the full sequence; two tokens; no duplicate issue during DONE.
- `md_resultRDY` never asserted with `LATENCY_MAX`=40 → DONE after 40 WAIT cycles; `timeout`=1 and stays 1 until reset; `wb_data`=0.
- Reset asserted at WAIT cycle 10, then `md_resultRDY` pulsed → all outputs 0, state IDLE, no token; non-md instructions (e.g. `add`, `addi`) never raise `stall`.
